// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter command sequencer.
package counter_ctrl_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned LW_DEF = 4;

  typedef enum logic [1:0] {
    GOTO   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2,
    RSVD   = 2'd3
  } cmd_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOTO,
    ST_SEEK_LO,
    ST_B_UP,
    ST_B_DN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/counter_seq_dir.sv
// Enable/direction decode: move the counter toward target, stop on arrival.
module counter_seq_dir #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] target,
  output logic         en_c,
  output logic         up_c
);

  // Unsigned compare keeps the direction free of wrap-around.
  always_comb begin
    en_c = (count != target);
    up_c = (target > count);
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer driving en/up_dn of an up/down counter (GOTO, BOUNCE, HOLD).
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [N-1:0]  cmd_lo,
  input  logic [N-1:0]  cmd_hi,
  input  logic [LW-1:0] cmd_legs,
  input  logic          abort,
  input  logic [N-1:0]  count,
  output logic          en,
  output logic          up_dn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state, state_nx;
  cmd_mode_e     mode_c;
  logic [N-1:0]  lo_q, hi_q, target;
  logic [LW-1:0] legs_q, legs_nx;
  logic          up_q, err_q;
  logic          accept, illegal, dir_en, dir_up;

  assign mode_c  = cmd_mode_e'(cmd_mode);
  assign accept  = cmd_valid && (state == ST_IDLE) && !abort;
  assign illegal = (mode_c == RSVD) || ((mode_c == BOUNCE) && (cmd_lo >= cmd_hi));

  counter_seq_dir #(.N(N)) u_dir (
    .count  (count),
    .target (target),
    .en_c   (dir_en),
    .up_c   (dir_up)
  );

  always_comb begin
    state_nx  = state;
    legs_nx   = legs_q;
    en        = 1'b0;
    target    = (state == ST_B_UP) ? hi_q : lo_q;
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_FIN);
    err       = err_q;
    case (state)
      ST_IDLE: begin
        if (accept && !illegal) begin
          case (mode_c)
            GOTO:    state_nx = (count == cmd_lo) ? ST_FIN : ST_GOTO;
            BOUNCE:  state_nx = ST_SEEK_LO;
            HOLD:    state_nx = ST_FIN;
            default: state_nx = ST_IDLE;
          endcase
        end
      end
      ST_GOTO: begin
        en = dir_en;
        if (!dir_en) state_nx = ST_FIN;
      end
      ST_SEEK_LO: begin
        en = dir_en;
        if (!dir_en) state_nx = (legs_q == '0) ? ST_FIN : ST_B_UP;
      end
      ST_B_UP, ST_B_DN: begin
        en = dir_en;
        // Each endpoint arrival completes one leg.
        if (!dir_en) begin
          legs_nx = legs_q - LW'(1);
          if (legs_q == LW'(1))     state_nx = ST_FIN;
          else if (state == ST_B_UP) state_nx = ST_B_DN;
          else                       state_nx = ST_B_UP;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) begin
      en       = 1'b0;
      legs_nx  = legs_q;
      state_nx = ST_IDLE;
    end
    // Direction holds its last driven value whenever the counter is idle.
    up_dn = en ? dir_up : up_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      lo_q   <= '0;
      hi_q   <= '0;
      legs_q <= '0;
      up_q   <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      up_q  <= up_dn;
      err_q <= accept && illegal;
      if (accept) begin
        lo_q   <= cmd_lo;
        hi_q   <= cmd_hi;
        legs_q <= cmd_legs;
      end else begin
        legs_q <= legs_nx;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized bench for counter_seq_ctrl with a trajectory-level reference model.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_lo = 8'd0;
  logic [7:0] cmd_hi = 8'd0;
  logic [3:0] cmd_legs = 4'd0;
  logic       abort = 1'b0;
  logic [7:0] count = 8'd0;
  logic       en, up_dn, busy, done, err;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit model_dir = 1'b1;

  counter_seq_ctrl #(.N(8), .LW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_legs  (cmd_legs),
    .abort     (abort),
    .count     (count),
    .en        (en),
    .up_dn     (up_dn),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Environment: the counter itself, not reset by the controller's reset.
  always @(posedge clk) if (en) count <= up_dn ? count + 8'd1 : count - 8'd1;

  task automatic push_walk(input int from, input int to);
    int v = from;
    exp_q.push_back(v);
    while (v != to) begin
      v += (to > from) ? 1 : -1;
      exp_q.push_back(v);
    end
  endtask

  // Expected per-cycle count trajectory from accept+1 through the done cycle.
  task automatic run_cmd(input int mode, input int lo, input int hi, input int legs,
                         input int stop_at, input bit use_rst, input string name);
    int c, cur, last;
    bit exp_en, exp_up;
    logic [11:0] got, want;
    @(negedge clk);
    c = int'(count);
    exp_q.delete();
    if (mode == 0) begin
      if (lo != c) push_walk(c, lo);
      exp_q.push_back(lo);
    end else if (mode == 2) begin
      exp_q.push_back(c);
    end else begin
      push_walk(c, lo);
      cur = lo;
      for (int l = 0; l < legs; l++) begin
        push_walk(cur, (l % 2 == 0) ? hi : lo);
        cur = (l % 2 == 0) ? hi : lo;
      end
      exp_q.push_back(cur);
    end
    last = exp_q.size() - 1;
    cmd_mode = 2'(mode); cmd_lo = 8'(lo); cmd_hi = 8'(hi); cmd_legs = 4'(legs);
    cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b expected 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= last; i++) begin
      if (i == stop_at) begin
        if (use_rst) rst_n = 1'b0; else abort = 1'b1;
        #1;
        got  = {count, en, up_dn, busy, done};
        want = use_rst ? {8'(exp_q[i]), 1'b0, 1'b1, 1'b0, 1'b0}
                       : {8'(exp_q[i]), 1'b0, model_dir, 1'b1, 1'b0};
        checks++;
        if (got !== want || err !== 1'b0) begin
          errors++; $display("FAIL %s stop cyc%0d: got %h err %b expected %h err 0", name, i, got, err, want);
        end
        if (use_rst) model_dir = 1'b1;
        @(negedge clk);
        abort = 1'b0; rst_n = 1'b1;
        #1;
        got  = {count, en, cmd_ready, busy, done};
        want = {8'(exp_q[i]), 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL %s after stop: got %h expected %h", name, got, want);
        end
        return;
      end
      #1;
      exp_en = (i < last) && (exp_q[i+1] != exp_q[i]);
      exp_up = exp_en ? (exp_q[i+1] > exp_q[i]) : model_dir;
      got  = {count, en, up_dn, busy, done};
      want = {8'(exp_q[i]), exp_en, exp_up, 1'b1, (i == last)};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL %s cyc%0d {count,en,up,busy,done}: got %h expected %h", name, i, got, want);
      end
      model_dir = exp_up;
      @(negedge clk);
    end
    #1;
    got  = {count, en, cmd_ready, busy, done};
    want = {8'(exp_q[last]), 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s idle: got %h expected %h", name, got, want);
    end
  endtask

  task automatic issue_illegal(input int mode, input int lo, input int hi, input string name);
    logic [7:0] c0;
    @(negedge clk);
    c0 = count;
    cmd_mode = 2'(mode); cmd_lo = 8'(lo); cmd_hi = 8'(hi); cmd_legs = 4'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if ({err, en, busy, cmd_ready, count} !== {1'b1, 1'b0, 1'b0, 1'b1, c0}) begin
      errors++; $display("FAIL %s err pulse: got err%b en%b busy%b rdy%b cnt%0d expected 1 0 0 1 %0d",
                         name, err, en, busy, cmd_ready, count, c0);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({err, en, busy} !== 3'b000) begin
      errors++; $display("FAIL %s err clear: got %b expected 000", name, {err, en, busy});
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({en, up_dn, busy, done, err} !== 5'b01000) begin
      errors++; $display("FAIL reset outputs: got %b expected 01000", {en, up_dn, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, en} !== 3'b100) begin
      errors++; $display("FAIL reset release: got %b expected 100", {cmd_ready, busy, en});
    end
  endtask

  task automatic test_goto;
    run_cmd(0, 5, 0, 0, -1, 1'b0, "goto5");
    run_cmd(0, 2, 0, 0, -1, 1'b0, "goto2");
    run_cmd(0, 2, 0, 0, -1, 1'b0, "goto2_again");
    run_cmd(0, 255, 0, 0, -1, 1'b0, "goto_max");
    run_cmd(0, 0, 0, 0, -1, 1'b0, "goto_min");
    for (int k = 0; k < 6; k++) run_cmd(0, int'($urandom_range(0, 255)), 0, 0, -1, 1'b0, "goto_rand");
  endtask

  task automatic test_hold;
    run_cmd(2, int'($urandom_range(0, 255)), 0, 0, -1, 1'b0, "hold");
  endtask

  task automatic test_bounce;
    int lo;
    run_cmd(0, 0, 0, 0, -1, 1'b0, "goto0");
    run_cmd(1, 2, 4, 3, -1, 1'b0, "bounce243");
    run_cmd(1, 7, 9, 0, -1, 1'b0, "bounce_nolegs");
    for (int k = 0; k < 4; k++) begin
      lo = int'($urandom_range(0, 200));
      run_cmd(1, lo, lo + int'($urandom_range(1, 20)), int'($urandom_range(0, 6)), -1, 1'b0, "bounce_rand");
    end
  endtask

  task automatic test_illegal;
    int lo;
    issue_illegal(1, 6, 6, "bounce_eq");
    issue_illegal(3, 1, 9, "mode3");
    for (int k = 0; k < 3; k++) begin
      lo = int'($urandom_range(0, 255));
      issue_illegal(1, lo, int'($urandom_range(0, lo)), "bounce_inv");
    end
  endtask

  task automatic test_abort;
    logic [7:0] c0;
    run_cmd(0, 0, 0, 0, -1, 1'b0, "goto0_ab");
    run_cmd(1, 2, 4, 3, 4, 1'b0, "abort_bup");
    @(negedge clk);
    c0 = count;
    cmd_mode = 2'd0; cmd_lo = c0 + 8'd10; cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if ({busy, en, cmd_ready, err, count} !== {1'b0, 1'b0, 1'b1, 1'b0, c0}) begin
      errors++; $display("FAIL abort_accept: got busy%b en%b rdy%b err%b cnt%0d expected 0 0 1 0 %0d",
                         busy, en, cmd_ready, err, count, c0);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL abort_accept done: got %b expected 00", {done, busy});
    end
  endtask

  task automatic test_reset_mid;
    run_cmd(0, 0, 0, 0, -1, 1'b0, "goto0_rst");
    run_cmd(1, 2, 4, 3, 6, 1'b1, "reset_mid");
    run_cmd(0, 1, 0, 0, -1, 1'b0, "goto1_post");
  endtask

  initial begin
    test_reset;
    test_goto;
    test_hold;
    test_bounce;
    test_illegal;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the N-bit up/down counter.
- Accepts one command at a time over a valid/ready handshake.
- Drives the counter's en and up_dn, watches the counter's count output, and signals completion.
- Sits between a test or software-facing command source and the counter instance. It is the only driver of en/up_dn.

Parameters:
- N, 8: counter width; width of count, cmd_lo, cmd_hi.
- LW, 4: width of the cmd_legs field (bounce leg budget).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_mode  input  2  0=GOTO, 1=BOUNCE, 2=HOLD, 3=reserved (flagged as error).
- cmd_lo  input  N  GOTO target; BOUNCE lower bound.
- cmd_hi  input  N  BOUNCE upper bound; ignored otherwise.
- cmd_legs  input  LW  BOUNCE: number of endpoint-to-endpoint legs.
- abort  input  1  cancel the current command.
- count  input  N  live counter value.
- en  output  1  counter enable.
- up_dn  output  1  counter direction; 1=up, 0=down.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, en=0, up_dn=1, busy=0, done=0, err=0.
  - cmd_ready=1 after reset release.
  - Latched lo/hi/legs cleared to 0.
- Handshake:
  - A command is accepted on a cycle where cmd_valid and cmd_ready are both high. Its fields are latched.
  - cmd_ready=0 from the following cycle until return to IDLE.
- States: IDLE, GOTO, SEEK_LO, B_UP, B_DN, FIN.
  - en and up_dn are combinational from the registered state, the latched fields and count.
  - The cycle in which count reaches an endpoint is therefore the cycle en drops. There is never overshoot.
- Command legality, checked at accept:
  - BOUNCE with lo>=hi, or mode 3: err pulses the next cycle, state stays IDLE, en stays 0.
  - HOLD: en=0; FIN the next cycle.
- GOTO:
  - en = (count != lo).
  - up_dn = (lo > count), compared unsigned. Direction never relies on wrap-around.
  - count==lo at accept: en never asserts; FIN the next cycle.
  - When count==lo: next state FIN.
- BOUNCE:
  - SEEK_LO drives toward lo exactly as GOTO, then enters B_UP.
  - legs==0: stops after SEEK_LO.
  - B_UP: en=1, up_dn=1. On count==hi, decrement the leg counter; go to B_DN, or FIN if the counter reaches 0.
  - B_DN: same as B_UP but down toward lo, then back to B_UP.
  - Endpoint-cycle en=0 as in GOTO.
- FIN: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- abort:
  - In any non-IDLE state, en is forced 0 in the same cycle. Next state is IDLE; done and err are not pulsed.
  - abort in IDLE has no effect. abort coinciding with accept: the command is discarded.
- External counter reset mid-command (count jumps to 0): the controller re-evaluates direction from the live count; no error is raised.
- up_dn holds its last driven value while en=0, so it never toggles spuriously.

Decomposition:
- Shared package counter_ctrl_pkg holds:
  - typedef enum cmd_mode_e {GOTO, BOUNCE, HOLD, RSVD}.
  - typedef enum of the state names.
  - Default N and LW localparams.
- One natural sub-module, counter_seq_dir: the combinational direction/enable decode (count vs target → en, up_dn). It is reused by both GOTO and SEEK_LO.
- The top holds the FSM, command latch and leg counter.

Test Plan:
- Reset, then GOTO lo=5 from count=0 → en=1 and up_dn=1 for 5 cycles, count=5, en=0 that same cycle, done pulses the next cycle, cmd_ready returns to 1.
- From count=5, GOTO lo=2 → up_dn=0, 3 enabled cycles, done; then GOTO lo=2 again → en never rises, done after 1 cycle.
- BOUNCE lo=2, hi=4, legs=3 from count=0 → count sequence 0,1,2,3,4,3,2,3,4, then done. Count never leaves [2,4] after the first arrival at 2.
- BOUNCE lo=6, hi=6 → err pulses once, en stays 0, cmd_ready stays 1. Repeat with mode 3 → same response.
- abort asserted during B_UP at count=3 → en=0 that cycle, count frozen at 3, IDLE next cycle, no done.
- Assert rst_n low mid-BOUNCE → all outputs at reset values immediately; after release the controller accepts GOTO lo=1 normally.
